// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store initiator for the shared word-wide data memory port.
// It takes one RV32 load/store at a time and issues word-aligned memory
// commands. Byte and halfword stores are done as read-modify-write, because
// the memory only accepts whole-word writes. Load data is lane-selected and
// then sign- or zero-extended. Misaligned, illegal and timed-out accesses
// are flagged. Each request ends with exactly one response pulse.
module lsu_mem_ctrl #(
  parameter logic [1:0] MEM_DISABLE   = 2'b00,
  parameter logic [1:0] MEM_READ_SEXT = 2'b01,
  parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
  parameter logic [1:0] MEM_WRITE     = 2'b11,
  parameter int         TIMEOUT       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic [1:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  input  logic        mem_ready
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ISSUE  = 3'd1,
    RD_WAIT   = 3'd2,
    RMW_ISSUE = 3'd3,
    RMW_WAIT  = 3'd4,
    WR_ISSUE  = 3'd5,
    RESP      = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    funct3_q, funct3_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    mem_op_q, mem_op_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic          illegal_s;
  logic          misaligned_s;

  // Pick the addressed lane from a little-endian word and extend it per funct3.
  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] lo,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = w[7:0];
    endcase
    h = lo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = w;
      3'd4:    r = {24'h000000, b};
      3'd5:    r = {16'h0000, h};
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  // Replace the addressed byte (SB) or halfword (SH) of the old word with store data.
  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [1:0] lo,
                                              input logic [31:0] old,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = old;
    if (f3[1:0] == 2'd0) begin
      case (lo)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        2'd3:    r[31:24] = wd[7:0];
        default: r = old;
      endcase
    end else if (lo[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

  // Classify the incoming request: illegal funct3 first, then alignment.
  always_comb begin
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    if (req_we) begin
      illegal_s = (req_funct3 > 3'd2);
    end else begin
      illegal_s = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
    end
    if (req_funct3[1:0] == 2'd1) begin
      misaligned_s = req_addr[0];
    end else if (req_funct3[1:0] == 2'd2) begin
      misaligned_s = (req_addr[1:0] != 2'd0);
    end else begin
      misaligned_s = 1'b0;
    end
  end

  // Next-state logic, response capture and registered memory command.
  always_comb begin
    state_d      = state_q;
    timer_d      = '0;
    funct3_d     = funct3_q;
    addr_lo_d    = addr_lo_q;
    wdata_d      = wdata_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_op_d     = MEM_DISABLE;
    resp_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid && mem_ready) begin
          funct3_d  = req_funct3;
          addr_lo_d = req_addr[1:0];
          wdata_d   = req_wdata[15:0];
          if (illegal_s || misaligned_s) begin
            state_d      = RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h00000000;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (!req_we) begin
              state_d = RD_ISSUE;
            end else if (req_funct3 == 3'd2) begin
              state_d     = WR_ISSUE;
              mem_wdata_d = req_wdata;
            end else begin
              state_d = RMW_ISSUE;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_WAIT;
      RD_WAIT: begin
        // A mem_valid arriving on the timeout cycle still wins.
        if (mem_valid) begin
          state_d      = RESP;
          resp_err_d   = 1'b0;
          resp_rdata_d = load_extract(funct3_q, addr_lo_q, mem_rdata);
        end else if (timer_q == TMAX) begin
          state_d      = RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h00000000;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RMW_ISSUE: state_d = RMW_WAIT;
      RMW_WAIT: begin
        if (mem_valid) begin
          state_d     = WR_ISSUE;
          mem_wdata_d = store_merge(funct3_q, addr_lo_q, mem_rdata, wdata_q);
        end else if (timer_q == TMAX) begin
          state_d      = RESP;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h00000000;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      WR_ISSUE: begin
        state_d      = RESP;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h00000000;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The command and response pulse are registered off the next state, so
    // each one is asserted for exactly the cycle spent in that state.
    case (state_d)
      RD_ISSUE:  mem_op_d = funct3_d[2] ? MEM_READ_ZEXT : MEM_READ_SEXT;
      RMW_ISSUE: mem_op_d = MEM_READ_ZEXT;
      WR_ISSUE:  mem_op_d = MEM_WRITE;
      default:   mem_op_d = MEM_DISABLE;
    endcase
    resp_valid_d = (state_d == RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      funct3_q     <= 3'd0;
      addr_lo_q    <= 2'd0;
      wdata_q      <= 16'h0000;
      mem_op_q     <= MEM_DISABLE;
      mem_addr_q   <= 32'h00000000;
      mem_wdata_q  <= 32'h00000000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h00000000;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      funct3_q     <= funct3_d;
      addr_lo_q    <= addr_lo_d;
      wdata_q      <= wdata_d;
      mem_op_q     <= mem_op_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE) && mem_ready;
  assign busy       = (state_q != IDLE);
  assign mem_op     = mem_op_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl. A small memory responder returns
// mem_word one cycle after every read command when enabled, and records
// every write command it sees.
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic [1:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_valid = 1'b0;
  logic        mem_ready = 1'b1;

  logic [31:0] mem_word = 32'h0;
  logic        mem_en = 1'b1;
  int          wr_count = 0;
  logic [31:0] last_wr_data = 32'h0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [1:0]  ops_seen [0:40];
  int          checks = 0;
  int          errors = 0;
  int          lat;
  int          wr_before;
  int          resp_seen;

  lsu_mem_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // Memory model: answer a read one cycle later, log writes.
  always begin
    logic was_read;
    @(posedge clk);
    was_read = ((mem_op == 2'b01) || (mem_op == 2'b10)) && mem_en;
    if (mem_op == 2'b11) begin
      wr_count     = wr_count + 1;
      last_wr_data = mem_wdata;
      last_wr_addr = mem_addr;
    end
    #1;
    mem_valid = was_read;
    mem_rdata = was_read ? mem_word : 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle; it is accepted at the next posedge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count cycles after the accept cycle until resp_valid, logging mem_op per cycle.
  task automatic wait_resp(output int l);
    l = -1;
    for (int k = 0; k <= 40; k++) ops_seen[k] = 2'b00;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      ops_seen[k] = mem_op;
      if (resp_valid) begin
        l = k;
        break;
      end
    end
  endtask

  initial begin
    // 1. Reset for three cycles.
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_mem_op", {30'b0, mem_op}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    reset = 1'b0;

    // mem_ready low blocks acceptance.
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("ready_gated", {31'b0, req_ready}, 32'd0);
    mem_ready = 1'b1;

    // 2. Loads from 0x1234F678 at 0x100.
    mem_word = 32'h1234F678;
    issue(1'b0, 3'd0, 32'h101, 32'h0);
    wait_resp(lat);
    check("lb_lat", 32'(lat), 32'd3);
    check("lb_op", {30'b0, ops_seen[1]}, 32'd1);
    check("lb_addr", mem_addr, 32'h100);
    check("lb_data", resp_rdata, 32'hFFFFFFF6);
    check("lb_err", {31'b0, resp_err}, 32'd0);
    @(negedge clk);
    check("resp_pulse_once", {31'b0, resp_valid}, 32'd0);
    check("rdata_holds", resp_rdata, 32'hFFFFFFF6);

    issue(1'b0, 3'd4, 32'h101, 32'h0);
    wait_resp(lat);
    check("lbu_op", {30'b0, ops_seen[1]}, 32'd2);
    check("lbu_data", resp_rdata, 32'h000000F6);

    issue(1'b0, 3'd5, 32'h102, 32'h0);
    wait_resp(lat);
    check("lhu_data", resp_rdata, 32'h00001234);

    issue(1'b0, 3'd1, 32'h100, 32'h0);
    wait_resp(lat);
    check("lh_data", resp_rdata, 32'hFFFFF678);

    issue(1'b0, 3'd2, 32'h100, 32'h0);
    wait_resp(lat);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_data", resp_rdata, 32'h1234F678);

    // 3. SH read-modify-write on 0x11223344.
    mem_word  = 32'h11223344;
    wr_before = wr_count;
    issue(1'b1, 3'd1, 32'h102, 32'hCAFEBEEF);
    wait_resp(lat);
    check("sh_lat", 32'(lat), 32'd4);
    check("sh_rd_op", {30'b0, ops_seen[1]}, 32'd2);
    check("sh_gap_op", {30'b0, ops_seen[2]}, 32'd0);
    check("sh_wr_op", {30'b0, ops_seen[3]}, 32'd3);
    check("sh_resp_op", {30'b0, ops_seen[4]}, 32'd0);
    check("sh_wr_count", 32'(wr_count - wr_before), 32'd1);
    check("sh_wr_data", last_wr_data, 32'hBEEF3344);
    check("sh_wr_addr", last_wr_addr, 32'h100);
    check("sh_err", {31'b0, resp_err}, 32'd0);
    check("sh_rdata", resp_rdata, 32'h0);

    // SB into byte lane 1.
    issue(1'b1, 3'd0, 32'h101, 32'h000000AB);
    wait_resp(lat);
    check("sb_wr_data", last_wr_data, 32'h1122AB44);

    // SW goes straight to a write.
    wr_before = wr_count;
    issue(1'b1, 3'd2, 32'h104, 32'hDEADBEEF);
    wait_resp(lat);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_op", {30'b0, ops_seen[1]}, 32'd3);
    check("sw_wr_data", last_wr_data, 32'hDEADBEEF);
    check("sw_wr_addr", last_wr_addr, 32'h104);
    check("sw_wr_count", 32'(wr_count - wr_before), 32'd1);

    // 4. Misaligned and illegal requests.
    issue(1'b0, 3'd2, 32'h103, 32'h0);
    wait_resp(lat);
    check("mis_lat", 32'(lat), 32'd1);
    check("mis_err", {31'b0, resp_err}, 32'd1);
    check("mis_rdata", resp_rdata, 32'h0);
    check("mis_op", {30'b0, ops_seen[1]}, 32'd0);

    wr_before = wr_count;
    issue(1'b1, 3'd3, 32'h100, 32'h12345678);
    wait_resp(lat);
    check("ill_lat", 32'(lat), 32'd1);
    check("ill_err", {31'b0, resp_err}, 32'd1);
    check("ill_op", {30'b0, ops_seen[1]}, 32'd0);
    check("ill_no_write", 32'(wr_count - wr_before), 32'd0);

    // 5. Timeout: memory never answers.
    mem_en   = 1'b0;
    mem_word = 32'h1234F678;
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    wait_resp(lat);
    check("to_lat", 32'(lat), 32'd10);
    check("to_err", {31'b0, resp_err}, 32'd1);
    check("to_rdata", resp_rdata, 32'h0);
    check("to_late_op", {30'b0, ops_seen[5]}, 32'd0);
    mem_en = 1'b1;
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    wait_resp(lat);
    check("after_to_lat", 32'(lat), 32'd3);
    check("after_to_data", resp_rdata, 32'h1234F678);
    check("after_to_err", {31'b0, resp_err}, 32'd0);

    // 6. Reset while waiting for the RMW read data.
    mem_en    = 1'b0;
    wr_before = wr_count;
    issue(1'b1, 3'd0, 32'h100, 32'h00000055);
    @(negedge clk);
    @(negedge clk);
    check("rmw_wait_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_mem_op", {30'b0, mem_op}, 32'd0);
    check("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    reset  = 1'b0;
    mem_en = 1'b1;
    resp_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid) resp_seen++;
    end
    check("abort_no_resp", 32'(resp_seen), 32'd0);
    check("abort_no_write", 32'(wr_count - wr_before), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
